// File: rtl/par_arb_pkg.sv
// Shared constants for the free-list page-request arbiter: port-ID width,
// default outstanding depth, and the page-address width define.
`ifndef LL_PG_ASZ
`define LL_PG_ASZ 12
`endif

package par_arb_pkg;

    localparam int PORT_CNT = 4;
    localparam int MAX_OUT  = 4;
    localparam int PAR_ID_W = $clog2(PORT_CNT);

    // Keeps a usable 1-bit ID even if a single port is ever configured.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/par_tag_fifo.sv
// In-order FIFO of requester IDs; one entry per issued, unanswered request.
module par_tag_fifo
    import par_arb_pkg::*;
#(
    parameter int W     = PAR_ID_W,
    parameter int DEPTH = MAX_OUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_tag,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty differ when indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_tag;
    end

endmodule

// File: rtl/par_arbiter.sv
// Round-robins per-port page requests onto one free-list channel and steers
// each page response back to the requester recorded at the tag FIFO head.
module par_arbiter
    import par_arb_pkg::*;
#(
    parameter int port_cnt = PORT_CNT,
    parameter int max_out  = MAX_OUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [port_cnt-1:0]          par_srdy,
    output logic [port_cnt-1:0]          par_drdy,
    output logic [port_cnt-1:0]          parr_srdy,
    output logic [`LL_PG_ASZ-1:0]        parr_page,
    input  logic [port_cnt-1:0]          parr_drdy,
    output logic                         fl_par_srdy,
    input  logic                         fl_par_drdy,
    input  logic                         fl_parr_srdy,
    input  logic [`LL_PG_ASZ-1:0]        fl_parr_page,
    output logic                         fl_parr_drdy,
    output logic [$clog2(max_out):0]     outstanding,
    output logic                         err_unexp
);

    localparam int ID_W = id_width(port_cnt);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W:0]   sum;
    logic            found;
    logic [ID_W-1:0] head;
    logic            tag_full;
    logic            tag_empty;
    logic            any_req;
    logic            push;
    logic            pop;

    // First requester at or after rr_ptr, wrapping modulo port_cnt.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < port_cnt; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(port_cnt))
                sum = sum - (ID_W+1)'(port_cnt);
            if (!found && par_srdy[sum[ID_W-1:0]]) begin
                grant = sum[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign any_req     = |par_srdy;
    assign fl_par_srdy = any_req && !tag_full;
    assign push        = fl_par_srdy && fl_par_drdy;

    always_comb begin
        par_drdy = '0;
        if (any_req && fl_par_drdy && !tag_full)
            par_drdy[grant] = 1'b1;
    end

    // Response steering never looks at parr_drdy for the valid side.
    always_comb begin
        parr_srdy = '0;
        if (fl_parr_srdy && !tag_empty)
            parr_srdy[head] = 1'b1;
    end

    assign parr_page    = fl_parr_page;
    assign fl_parr_drdy = parr_drdy[head] && !tag_empty;
    assign pop          = fl_parr_srdy && fl_parr_drdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (push)
                rr_ptr <= (grant == ID_W'(port_cnt - 1)) ? '0 : grant + 1'b1;
            if (fl_parr_srdy && tag_empty)
                err_unexp <= 1'b1;
        end
    end

    par_tag_fifo #(
        .W     (ID_W),
        .DEPTH (max_out)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (grant),
        .pop      (pop),
        .head     (head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (outstanding)
    );

endmodule
